// File: rtl/vga_timing_gen_if.sv
// ============================================================================
// Module      : vga_timing_gen_if
// Description : Signal bundle between the VGA timing generator and its
//               consumers (renderer, frame logic).
//               Ports / members:
//                 pixel_en      consumer -> generator, advance enable
//                 DrawX, DrawY  current pixel position (10 bits each)
//                 hs, vs        active-low horizontal / vertical sync
//                 blank         1 = visible pixel
//                 sync          composite sync (always 0)
//                 frame_start   one-cycle pulse on entry to (0,0)
//                 vblank_start  one-cycle pulse on entry to (0,V_VISIBLE)
//                 frame_count   completed-frame counter (16 bits)
//               Modport master is the generator side; slave is the consumer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface vga_timing_gen_if;
  logic        pixel_en;
  logic [9:0]  DrawX;
  logic [9:0]  DrawY;
  logic        hs;
  logic        vs;
  logic        blank;
  logic        sync;
  logic        frame_start;
  logic        vblank_start;
  logic [15:0] frame_count;

  modport master (
    input  pixel_en,
    output DrawX, DrawY, hs, vs, blank, sync,
    output frame_start, vblank_start, frame_count
  );

  modport slave (
    output pixel_en,
    input  DrawX, DrawY, hs, vs, blank, sync,
    input  frame_start, vblank_start, frame_count
  );
endinterface

`default_nettype wire

// File: rtl/vga_timing_gen.sv
// ============================================================================
// Module      : vga_timing_gen
// Description : VGA raster timing generator. Walks a pixel position across
//               an H_TOTAL x V_TOTAL raster one step per enabled clock and
//               produces sync, blanking, frame markers and a frame counter.
//               Ports:
//                 vga_clk   sole clock, rising edge
//                 reset_n   synchronous active-low reset
//                 vif       vga_timing_gen_if.master (pixel_en in, timing out)
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module vga_timing_gen #(
  parameter int H_VISIBLE = 640,
  parameter int H_FP      = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BP      = 48,
  parameter int V_VISIBLE = 480,
  parameter int V_FP      = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BP      = 33
) (
  input  logic                   vga_clk,
  input  logic                   reset_n,
  vga_timing_gen_if.master       vif
);

  localparam int c_h_total = H_VISIBLE + H_FP + H_SYNC + H_BP;
  localparam int c_v_total = V_VISIBLE + V_FP + V_SYNC + V_BP;

  // All boundaries pre-sized to the counter width so every compare is 10-bit.
  localparam logic [9:0] c_h_last     = 10'(c_h_total - 1);
  localparam logic [9:0] c_v_last     = 10'(c_v_total - 1);
  localparam logic [9:0] c_h_vis      = 10'(H_VISIBLE);
  localparam logic [9:0] c_v_vis      = 10'(V_VISIBLE);
  localparam logic [9:0] c_v_vis_last = 10'(V_VISIBLE - 1);
  localparam logic [9:0] c_hs_start   = 10'(H_VISIBLE + H_FP);
  localparam logic [9:0] c_hs_end     = 10'(H_VISIBLE + H_FP + H_SYNC);
  localparam logic [9:0] c_vs_start   = 10'(V_VISIBLE + V_FP);
  localparam logic [9:0] c_vs_end     = 10'(V_VISIBLE + V_FP + V_SYNC);

  logic [9:0]  r_x;
  logic [9:0]  r_y;
  logic        r_hs;
  logic        r_vs;
  logic        r_blank;
  logic        r_frame_start;
  logic        r_vblank_start;
  logic [15:0] r_frame_count;

  logic [9:0]  w_next_x;
  logic [9:0]  w_next_y;
  logic        w_h_wrap;
  logic        w_v_wrap;
  logic        w_frame_adv;
  logic        w_vblank_adv;
  logic        w_hs_n;
  logic        w_vs_n;
  logic        w_blank;

  // Next-position logic. Sync/blank decode is taken from the next position so
  // the registered decode lines up with the registered counters it describes.
  always_comb begin
    w_next_x     = r_x;
    w_next_y     = r_y;
    w_h_wrap     = (r_x == c_h_last);
    w_v_wrap     = (r_y == c_v_last);
    w_frame_adv  = vif.pixel_en && w_h_wrap && w_v_wrap;
    w_vblank_adv = vif.pixel_en && w_h_wrap && (r_y == c_v_vis_last);

    if (vif.pixel_en) begin
      if (w_h_wrap) begin
        w_next_x = '0;
        if (w_v_wrap) begin
          w_next_y = '0;
        end else begin
          w_next_y = r_y + 10'd1;
        end
      end else begin
        w_next_x = r_x + 10'd1;
      end
    end

    w_hs_n  = !((w_next_x >= c_hs_start) && (w_next_x < c_hs_end));
    w_vs_n  = !((w_next_y >= c_vs_start) && (w_next_y < c_vs_end));
    w_blank = (w_next_x < c_h_vis) && (w_next_y < c_v_vis);
  end

  always_ff @(posedge vga_clk) begin
    if (!reset_n) begin
      r_x            <= '0;
      r_y            <= '0;
      r_hs           <= 1'b1;
      r_vs           <= 1'b1;
      r_blank        <= 1'b0;
      r_frame_start  <= 1'b0;
      r_vblank_start <= 1'b0;
      r_frame_count  <= '0;
    end else begin
      r_x            <= w_next_x;
      r_y            <= w_next_y;
      r_hs           <= w_hs_n;
      r_vs           <= w_vs_n;
      r_blank        <= w_blank;
      // Pulses come only from an actual advance into the marker position, so
      // sitting on (0,0) with pixel_en low or leaving reset never fires them.
      r_frame_start  <= w_frame_adv;
      r_vblank_start <= w_vblank_adv;
      if (w_frame_adv) begin
        r_frame_count <= r_frame_count + 16'd1;
      end
    end
  end

  assign vif.DrawX        = r_x;
  assign vif.DrawY        = r_y;
  assign vif.hs           = r_hs;
  assign vif.vs           = r_vs;
  assign vif.blank        = r_blank;
  assign vif.sync         = 1'b0;
  assign vif.frame_start  = r_frame_start;
  assign vif.vblank_start = r_vblank_start;
  assign vif.frame_count  = r_frame_count;

endmodule

`default_nettype wire

// File: doc/vga_timing_gen.md
VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

Interface
REQ-001 Parameters (name, default, meaning): H_VISIBLE 640 active pixels per line; H_FP 16 front porch; H_SYNC 96 sync width; H_BP 48 back porch; V_VISIBLE 480 active lines; V_FP 10; V_SYNC 2; V_BP 33.
REQ-002 H_TOTAL = sum of H params (default 800); V_TOTAL = sum of V params (default 525); both derived, not overridable.
REQ-003 Ports (name, direction, width, meaning):
REQ-004 vga_clk  in  1  sole clock; all state updates on rising edge.
REQ-005 reset_n  in  1  synchronous, active-low reset, sampled on rising vga_clk.
REQ-006 pixel_en  in  1  advance enable; counters step one pixel per vga_clk with pixel_en=1.
REQ-007 DrawX  out  10  current horizontal count, 0..H_TOTAL-1.
REQ-008 DrawY  out  10  current vertical count, 0..V_TOTAL-1.
REQ-009 hs  out  1  horizontal sync, active-low.
REQ-010 vs  out  1  vertical sync, active-low.
REQ-011 blank  out  1  display enable, 1 = visible pixel (downstream renderer drives colour only when 1).
REQ-012 sync  out  1  composite sync, tied 0.
REQ-013 frame_start  out  1  one-cycle pulse on entry to (0,0).
REQ-014 vblank_start  out  1  one-cycle pulse on entry to (0,V_VISIBLE).
REQ-015 frame_count  out  16  completed-frame counter.

Function
REQ-016 All outputs except sync are registers; no combinational path from inputs to outputs.
REQ-017 With pixel_en=1: DrawX increments by 1; at H_TOTAL-1 it wraps to 0 and DrawY increments; at (H_TOTAL-1, V_TOTAL-1) both wrap to 0.
REQ-018 With pixel_en=0: DrawX, DrawY, frame_count hold; hs/vs/blank keep their decode of held counts.
REQ-019 hs, vs, blank are registered from the next-state counters, so they are cycle-aligned with the DrawX/DrawY they describe (zero relative latency).
REQ-020 hs=0 iff H_VISIBLE+H_FP <= DrawX < H_VISIBLE+H_FP+H_SYNC (default 656..751).
REQ-021 vs=0 iff V_VISIBLE+V_FP <= DrawY < V_VISIBLE+V_FP+V_SYNC (default 490..491).
REQ-022 blank=1 iff DrawX < H_VISIBLE and DrawY < V_VISIBLE.
REQ-023 frame_start=1 for exactly the one vga_clk cycle in which counters have just advanced (pixel_en=1) from (H_TOTAL-1,V_TOTAL-1) to (0,0); 0 otherwise, including while pixel_en=0 holds (0,0).
REQ-024 vblank_start=1 for exactly the one cycle after advance from (H_TOTAL-1,V_VISIBLE-1) to (0,V_VISIBLE).
REQ-025 frame_count increments by 1 in the same cycle frame_start asserts; wraps 65535 -> 0.
REQ-026 Counter widths: 10 bits; arithmetic never exceeds H_TOTAL-1/V_TOTAL-1 and no out-of-range value is ever output.

Reset
REQ-027 While reset_n=0 at a rising edge: DrawX=0, DrawY=0, hs=1, vs=1, blank=0, frame_start=0, vblank_start=0, frame_count=0.
REQ-028 Reset overrides pixel_en; reset asserted mid-line or mid-frame returns to (0,0) on that edge with no frame_start or frame_count increment.
REQ-029 First edge after reset_n=1: blank takes decode of (0,0) = 1; counters advance only if pixel_en=1; no frame_start for the reset-entered (0,0).

Verification
REQ-030 Reset then pixel_en=1 for 420000 cycles -> DrawX sequence 0..799 repeating; hs low exactly 96 cycles per line starting at DrawX=656; blank high 640 cycles per line for DrawY 0..479.
REQ-031 Full frame, pixel_en=1 -> 800*525 = 420000 cycles between frame_start pulses; vs low for 1600 cycles starting at (0,490); vblank_start once per frame at (0,480); frame_count 0->1->2.
REQ-032 pixel_en toggled 1,0,1,0 across (799,524)->(0,0) -> frame_start high for one cycle only, counts held during pixel_en=0, frame_count increments once.
REQ-033 Reset asserted at (300,200) for 1 cycle -> next outputs (0,0), hs=1, vs=1, blank=0, frame_count=0; following cycle blank=1.
REQ-034 Force frame_count to 65535 (run 65536 frames or preload in sim) -> next frame_start gives frame_count=0.
REQ-035 Every cycle, checker asserts blank/hs/vs equal decode of the DrawX/DrawY output in that same cycle.
